// File: rtl/writeback.sv
// writeback: final pipeline stage. Classifies each slot from the memory stage,
// issues a registered register-file write port back to decode and keeps
// retire / bubble / write counters. All state updates on the clock's falling
// edge so decode sees a stable port on the following rising edge.

`ifndef PC_WIDTH
`define PC_WIDTH      16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH     16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH  8
`endif
`ifndef OP_ADD_D
`define OP_ADD_D      8'h01
`define OP_ADDI_D     8'h02
`define OP_AND_D      8'h03
`define OP_ANDI_D     8'h04
`define OP_MOV        8'h05
`define OP_MOVI_D     8'h06
`define OP_LDW        8'h07
`define OP_STW        8'h08
`define OP_JMP        8'h09
`define OP_JSR        8'h0A
`define OP_JSRR       8'h0B
`define OP_BRN        8'h10
`define OP_BRZ        8'h11
`define OP_BRP        8'h12
`define OP_BRNZ       8'h13
`define OP_BRNP       8'h14
`define OP_BRZP       8'h15
`define OP_BRNZP      8'h16
`endif

module writeback #(
    parameter int CNT_WIDTH = 16,
    parameter int LINK_REG  = 7
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_LOCK,
    input  logic [`PC_WIDTH-1:0]     I_PC,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [`REG_WIDTH-1:0]    I_ALUOut,
    input  logic [`REG_WIDTH-1:0]    I_MemOut,
    input  logic                     I_FetchStall,
    input  logic                     I_DepStall,
    output logic                     O_WriteBackEnable,
    output logic [3:0]               O_WriteBackRegIdx,
    output logic [`REG_WIDTH-1:0]    O_WriteBackData,
    output logic [CNT_WIDTH-1:0]     O_RetireCount,
    output logic [CNT_WIDTH-1:0]     O_BubbleCount,
    output logic [CNT_WIDTH-1:0]     O_WriteCount,
    output logic                     O_Active
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                  state;
    logic                    slot_bubble;
    logic                    wr_en;
    logic [3:0]              wr_idx;
    logic [`REG_WIDTH-1:0]   wr_data;

    // Decode the presented slot into a bubble flag and the write it would issue
    always_comb begin
        slot_bubble = I_FetchStall | I_DepStall;
        wr_en       = 1'b0;
        wr_idx      = I_DestRegIdx;
        wr_data     = I_ALUOut;
        if (!slot_bubble) begin
            case (I_Opcode)
                `OP_ADD_D, `OP_ADDI_D, `OP_AND_D, `OP_ANDI_D, `OP_MOV, `OP_MOVI_D: begin
                    wr_en = 1'b1;
                end
                `OP_LDW: begin
                    wr_en   = 1'b1;
                    wr_data = I_MemOut;
                end
                `OP_JSR, `OP_JSRR: begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'(LINK_REG);
                    wr_data = `REG_WIDTH'(I_PC);
                end
                default: begin
                    wr_en = 1'b0;
                end
            endcase
        end
    end

    // State, write port and counters, all updated on the falling edge
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state             <= IDLE;
            O_WriteBackEnable <= 1'b0;
            O_WriteBackRegIdx <= '0;
            O_WriteBackData   <= '0;
            O_RetireCount     <= '0;
            O_BubbleCount     <= '0;
            O_WriteCount      <= '0;
        end else begin
            O_WriteBackEnable <= 1'b0;
            case (state)
                IDLE:    if (I_LOCK)  state <= ACTIVE;
                ACTIVE:  if (!I_LOCK) state <= IDLE;
                default: state <= IDLE;
            endcase
            // The IDLE->ACTIVE edge also consumes the slot presented with it
            if (I_LOCK) begin
                if (slot_bubble) begin
                    O_BubbleCount <= O_BubbleCount + CNT_WIDTH'(1);
                end else begin
                    O_RetireCount <= O_RetireCount + CNT_WIDTH'(1);
                end
                if (wr_en) begin
                    O_WriteBackEnable <= 1'b1;
                    O_WriteBackRegIdx <= wr_idx;
                    O_WriteBackData   <= wr_data;
                    O_WriteCount      <= O_WriteCount + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Active flag is a direct decode of the state register
    always_comb begin
        O_Active = (state == ACTIVE);
    end

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: each driven slot pushes the expected port
// and counter values; a monitor pops one entry per falling edge and compares.

`ifndef PC_WIDTH
`define PC_WIDTH      16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH     16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH  8
`endif
`ifndef OP_ADD_D
`define OP_ADD_D      8'h01
`define OP_ADDI_D     8'h02
`define OP_AND_D      8'h03
`define OP_ANDI_D     8'h04
`define OP_MOV        8'h05
`define OP_MOVI_D     8'h06
`define OP_LDW        8'h07
`define OP_STW        8'h08
`define OP_JMP        8'h09
`define OP_JSR        8'h0A
`define OP_JSRR       8'h0B
`define OP_BRN        8'h10
`define OP_BRZ        8'h11
`define OP_BRP        8'h12
`define OP_BRNZ       8'h13
`define OP_BRNP       8'h14
`define OP_BRZP       8'h15
`define OP_BRNZP      8'h16
`endif

module tb_writeback;

    localparam int CW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lock;
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [3:0]  dest;
    logic [15:0] alu_out;
    logic [15:0] mem_out;
    logic        fetch_stall;
    logic        dep_stall;
    logic        wb_en;
    logic [3:0]  wb_idx;
    logic [15:0] wb_data;
    logic [CW-1:0] retire_cnt, bubble_cnt, write_cnt;
    logic        active;

    int tests = 0;
    int fails = 0;

    writeback #(.CNT_WIDTH(CW), .LINK_REG(7)) dut (
        .I_CLOCK           (clk),
        .I_RESET_N         (rst_n),
        .I_LOCK            (lock),
        .I_PC              (pc),
        .I_Opcode          (opcode),
        .I_DestRegIdx      (dest),
        .I_ALUOut          (alu_out),
        .I_MemOut          (mem_out),
        .I_FetchStall      (fetch_stall),
        .I_DepStall        (dep_stall),
        .O_WriteBackEnable (wb_en),
        .O_WriteBackRegIdx (wb_idx),
        .O_WriteBackData   (wb_data),
        .O_RetireCount     (retire_cnt),
        .O_BubbleCount     (bubble_cnt),
        .O_WriteCount      (write_cnt),
        .O_Active          (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  idx;
        logic [15:0] data;
        logic [15:0] rc;
        logic [15:0] bc;
        logic [15:0] wc;
        logic        act;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;

    // Reference model state: what the port and counters should read after each edge
    logic [3:0]  m_idx;
    logic [15:0] m_data;
    logic [15:0] m_rc, m_bc, m_wc;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = '0; m_data = '0; m_rc = '0; m_bc = '0; m_wc = '0;
    endtask

    // Drive one slot just after a rising edge and push what it should produce
    task automatic drive_slot(input logic l, input logic [7:0] op, input logic [3:0] d,
                              input logic [15:0] alu, input logic [15:0] mem,
                              input logic [15:0] p, input logic fs, input logic ds);
        exp_t e;
        bit   writes;
        logic [3:0]  w_idx;
        logic [15:0] w_data;
        @(posedge clk);
        #1;
        lock = l; opcode = op; dest = d; alu_out = alu; mem_out = mem;
        pc = p; fetch_stall = fs; dep_stall = ds;

        writes = 1'b0;
        w_idx  = d;
        w_data = alu;
        if (op inside {`OP_ADD_D, `OP_ADDI_D, `OP_AND_D, `OP_ANDI_D, `OP_MOV, `OP_MOVI_D}) begin
            writes = 1'b1;
        end else if (op == `OP_LDW) begin
            writes = 1'b1; w_data = mem;
        end else if (op inside {`OP_JSR, `OP_JSRR}) begin
            writes = 1'b1; w_idx = 4'd7; w_data = p;
        end

        e.en = 1'b0;
        if (l) begin
            if (fs || ds) begin
                m_bc = m_bc + 16'd1;
            end else begin
                m_rc = m_rc + 16'd1;
                if (writes) begin
                    e.en   = 1'b1;
                    m_idx  = w_idx;
                    m_data = w_data;
                    m_wc   = m_wc + 16'd1;
                end
            end
        end
        e.idx = m_idx; e.data = m_data;
        e.rc = m_rc; e.bc = m_bc; e.wc = m_wc;
        e.act = l;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per falling edge after a driven slot
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wb_enable", 32'(wb_en),      32'(e.en));
                check("wb_regidx", 32'(wb_idx),     32'(e.idx));
                check("wb_data",   32'(wb_data),    32'(e.data));
                check("retire",    32'(retire_cnt), 32'(e.rc));
                check("bubble",    32'(bubble_cnt), 32'(e.bc));
                check("writes",    32'(write_cnt),  32'(e.wc));
                check("active",    32'(active),     32'(e.act));
            end
        end
    end

    // Watchdog bounding total run time
    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] op_pool [18];

    initial begin
        op_pool = '{`OP_ADD_D, `OP_ADDI_D, `OP_AND_D, `OP_ANDI_D, `OP_MOV, `OP_MOVI_D,
                    `OP_LDW, `OP_STW, `OP_JMP, `OP_JSR, `OP_JSRR, `OP_BRN, `OP_BRZ,
                    `OP_BRP, `OP_BRNZP, 8'h00, 8'h3C, 8'hFF};

        rst_n = 1'b0; lock = 1'b0; pc = '0; opcode = '0; dest = '0;
        alu_out = '0; mem_out = '0; fetch_stall = 1'b0; dep_stall = 1'b0;
        model_reset();

        // Asynchronous reset values, sampled before any clock edge
        #3;
        check("rst_enable", 32'(wb_en), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_retire", 32'(retire_cnt), 32'd0);
        check("rst_data",   32'(wb_data), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Idle with stale inputs
        drive_slot(1'b0, `OP_ADD_D, 4'd9, 16'hDEAD, 16'h0, 16'h0, 1'b0, 1'b0);
        drive_slot(1'b0, `OP_ADD_D, 4'd9, 16'hDEAD, 16'h0, 16'h0, 1'b0, 1'b0);

        // Directed slots
        drive_slot(1'b1, `OP_ADDI_D, 4'd3, 16'h0005, 16'h0,    16'h0010, 1'b0, 1'b0);
        drive_slot(1'b1, 8'h00,      4'd0, 16'h0000, 16'h0,    16'h0011, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_LDW,    4'd2, 16'h0100, 16'h00AA, 16'h0012, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_ADD_D,  4'd4, 16'h0007, 16'h0,    16'h0013, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_JSR,    4'd5, 16'h1111, 16'h0,    16'h0042, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_STW,    4'd6, 16'h2222, 16'h3333, 16'h0043, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_BRZ,    4'd6, 16'h2222, 16'h3333, 16'h0044, 1'b0, 1'b0);
        drive_slot(1'b1, `OP_MOVI_D, 4'd1, 16'h0077, 16'h0,    16'h0045, 1'b0, 1'b1);
        drive_slot(1'b1, `OP_ADD_D,  4'd1, 16'h0078, 16'h0,    16'h0046, 1'b1, 1'b0);
        drive_slot(1'b1, `OP_AND_D,  4'd1, 16'h0079, 16'h0,    16'h0047, 1'b1, 1'b1);
        drive_slot(1'b1, `OP_JSRR,   4'd2, 16'h0,    16'h0,    16'hBEEF, 1'b0, 1'b0);
        drive_slot(1'b0, `OP_MOV,    4'd8, 16'h5555, 16'h0,    16'h0,    1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive_slot(($urandom_range(9, 0) != 0),
                       op_pool[$urandom_range(17, 0)],
                       4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
        end

        // Bring the retire counter to all-ones, then wrap it with one more slot
        while (m_rc != 16'hFFFF) begin
            drive_slot(1'b1, `OP_STW, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        end
        drive_slot(1'b1, `OP_BRNZP, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check("retire_wrap", 32'(retire_cnt), 32'd0);

        // Reset asserted mid-strobe, between the rising and falling edge
        drive_slot(1'b1, `OP_ADDI_D, 4'd9, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check("pre_rst_enable", 32'(wb_en), 32'd1);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        lock  = 1'b0;
        #1;
        check("midrst_enable", 32'(wb_en),      32'd0);
        check("midrst_regidx", 32'(wb_idx),     32'd0);
        check("midrst_data",   32'(wb_data),    32'd0);
        check("midrst_retire", 32'(retire_cnt), 32'd0);
        check("midrst_bubble", 32'(bubble_cnt), 32'd0);
        check("midrst_writes", 32'(write_cnt),  32'd0);
        check("midrst_active", 32'(active),     32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        check("idle_active", 32'(active), 32'd0);
        check("idle_enable", 32'(wb_en),  32'd0);
        check("idle_retire", 32'(retire_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
